// File: rtl/proc_pkg.sv
// Shared processor constants and the fetch FSM state type.
// Imported by the fetch unit and its sub-blocks.
package proc_pkg;

  localparam int PC_W       = 16;
  localparam int INSTR_W    = 32;
  localparam logic [PC_W-1:0] RESET_PC = 16'h0000;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DROP     = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} buffer between instruction memory and decode.
// Flush wins over push and pop; head entry is driven straight from registers.
module fetch_fifo #(
  parameter int PC_W    = proc_pkg::PC_W,
  parameter int INSTR_W = proc_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [PC_W-1:0]    push_pc_i,
  input  logic [INSTR_W-1:0] push_instr_i,
  input  logic               pop_i,
  output logic [1:0]         count_o,
  output logic               valid_o,
  output logic [PC_W-1:0]    pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic [PC_W-1:0]    pc_q  [2];
  logic [INSTR_W-1:0] ins_q [2];
  logic               rd_q;
  logic               wr_q;
  logic [1:0]         cnt_q;
  logic               do_pop;
  logic               do_push;

  assign do_pop  = pop_i && (cnt_q != 2'd0) && !flush_i;
  assign do_push = push_i && !flush_i &&
                   ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q[0]  <= '0;
      pc_q[1]  <= '0;
      ins_q[0] <= '0;
      ins_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) begin
        pc_q[wr_q]  <= push_pc_i;
        ins_q[wr_q] <= push_instr_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end

  assign count_o = cnt_q;
  assign valid_o = (cnt_q != 2'd0);
  assign pc_o    = pc_q[rd_q];
  assign instr_o = ins_q[rd_q];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding memory read, redirect flush,
// and a two-entry buffer feeding decode.
module instr_fetch #(
  parameter int              PC_W     = proc_pkg::PC_W,
  parameter int              INSTR_W  = proc_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = proc_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [PC_W-1:0]    dec_pc
);

  import proc_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic            push;
  logic [1:0]      buf_cnt;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
        end else if (buf_cnt < 2'd2) begin
          state_d = WAIT_ACK;
          addr_d  = fetch_pc_q;
        end
      end
      WAIT_ACK: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
          state_d    = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = addr_q + PC_W'(1);
          state_d    = IDLE;
        end
      end
      DROP: begin
        // the in-flight read belongs to a stale path; just retire it
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
        end
        if (imem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  assign imem_req  = (state_q != IDLE);
  assign imem_addr = addr_q;

  fetch_fifo #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (redirect_valid),
    .push_i       (push),
    .push_pc_i    (addr_q),
    .push_instr_i (imem_rdata),
    .pop_i        (dec_valid && dec_ready),
    .count_o      (buf_cnt),
    .valid_o      (dec_valid),
    .pc_o         (dec_pc),
    .instr_o      (dec_instr)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and random bench for instr_fetch against an in-order
// instruction-stream model with a variable-latency memory responder.
module tb_instr_fetch;

  localparam int PW = 16;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic          dec_valid;
  logic          dec_ready;
  logic [IW-1:0] dec_instr;
  logic [PW-1:0] dec_pc;

  logic          w_req;
  logic [PW-1:0] w_addr;
  logic          w_ack;
  logic [IW-1:0] w_rdata;
  logic          w_redir;
  logic [PW-1:0] w_rpc;
  logic          w_valid;
  logic          w_ready;
  logic [IW-1:0] w_instr;
  logic [PW-1:0] w_pc;

  logic [31:0] salt;

  instr_fetch u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc)
  );

  instr_fetch #(.RESET_PC(16'hFFFE)) u_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (w_req),
    .imem_addr      (w_addr),
    .imem_ack       (w_ack),
    .imem_rdata     (w_rdata),
    .redirect_valid (w_redir),
    .redirect_pc    (w_rpc),
    .dec_valid      (w_valid),
    .dec_ready      (w_ready),
    .dec_instr      (w_instr),
    .dec_pc         (w_pc)
  );

  // zero-wait memory for the wrap instance
  assign w_ack   = w_req;
  assign w_rdata = {w_addr ^ salt[31:16], ~w_addr ^ salt[15:0]};
  assign w_redir = 1'b0;
  assign w_rpc   = '0;
  assign w_ready = 1'b1;

  function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
    return {a ^ salt[31:16], ~a ^ salt[15:0]};
  endfunction

  int errors = 0;
  int checks = 0;

  logic [PW-1:0] exp_pc, exp2, last_acc_pc, raddr;
  int            n_acc, n_ack, cnt, lat;
  bit            flush_chk, outst, seen_wrap, last_redir;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at posedge+1.
  // rmode: 0 none, 1 redirect now, 2 redirect only if ack this cycle
  task automatic cyc(input bit rdy, input int rmode,
                     input logic [PW-1:0] rpc);
    bit ackn, redir;
    if (flush_chk) begin
      chk("flush_valid", dec_valid, 1'b0);
      flush_chk = 0;
    end
    if (outst && !imem_req) chk("req_held", imem_req, 1'b1);
    if (imem_req && outst) chk("addr_stable", imem_addr, raddr);
    if (imem_req && !outst) begin
      outst = 1;
      cnt   = lat;
      raddr = imem_addr;
    end
    ackn = imem_req && outst && (cnt == 0);
    if (outst && !ackn) cnt--;
    redir = (rmode == 1) || (rmode == 2 && ackn);
    last_redir = redir;
    if (dec_valid && rdy && !redir) begin
      chk("dec_pc", dec_pc, exp_pc);
      chk("dec_instr", dec_instr, mem_word(exp_pc));
      last_acc_pc = dec_pc;
      exp_pc = exp_pc + 16'd1;
      n_acc++;
    end
    if (redir) begin
      exp_pc    = rpc;
      flush_chk = 1;
    end
    if (w_valid) begin
      chk("wrap_pc", w_pc, exp2);
      chk("wrap_instr", w_instr, mem_word(exp2));
      if (exp2 == 16'h0000) seen_wrap = 1;
      exp2 = exp2 + 16'd1;
    end
    imem_ack       = ackn;
    imem_rdata     = ackn ? mem_word(raddr) : IW'($urandom);
    dec_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = redir ? rpc : PW'($urandom);
    if (ackn) begin
      outst = 0;
      n_ack++;
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset entered at posedge+1; ack held high is ignored.
  task automatic do_reset();
    rst_n          = 1'b0;
    imem_ack       = 1'b1;
    imem_rdata     = '1;
    dec_ready      = 1'b1;
    redirect_valid = 1'b0;
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_valid", dec_valid, 1'b0);
    chk("rst_instr", dec_instr, 32'h0);
    chk("rst_pc", dec_pc, 16'h0000);
    chk("rst_waddr", w_addr, 16'hFFFE);
    chk("rst_wvalid", w_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    imem_ack  = 1'b0;
    rst_n     = 1'b1;
    exp_pc    = 16'h0000;
    exp2      = 16'hFFFE;
    n_acc     = 0;
    n_ack     = 0;
    outst     = 0;
    cnt       = 0;
    flush_chk = 0;
    chk("rel_req", imem_req, 1'b0);
    chk("rel_valid", dec_valid, 1'b0);
  endtask

  initial begin
    bit found;
    salt           = $urandom;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    dec_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    lat            = 0;
    seen_wrap      = 0;
    @(posedge clk);
    #1;
    do_reset();

    // zero-wait stream, decode always ready
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      chk("req_alt", imem_req, (i % 2 == 1));
      cyc(1'b1, 0, '0);
    end
    chk("seq_count", n_acc, 4);

    // decode stalled: buffer fills to two, fetch stops
    do_reset();
    repeat (10) cyc(1'b0, 0, '0);
    chk("stall_acks", n_ack, 2);
    chk("stall_req", imem_req, 1'b0);
    chk("stall_valid", dec_valid, 1'b1);
    chk("stall_head", dec_pc, 16'h0000);
    repeat (12) cyc(1'b1, 0, '0);
    chk("stall_drain", (n_acc > 2), 1'b1);

    // redirect while a slow read is outstanding and buffer non-empty
    do_reset();
    lat = 3;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (dec_valid && imem_req) found = 1;
      else cyc(1'b0, 0, '0);
    end
    chk("drop_setup", found, 1'b1);
    cyc(1'b0, 1, 16'h0040);
    n_acc = 0;
    for (int i = 0; i < 30 && n_acc == 0; i++) cyc(1'b1, 0, '0);
    chk("redir_first", last_acc_pc, 16'h0040);

    // redirect coincident with ack
    lat = 1;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      cyc(1'b1, 2, 16'h1234);
      found = last_redir;
    end
    chk("redir_ack_seen", found, 1'b1);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_req) found = 1;
      else cyc(1'b1, 0, '0);
    end
    chk("redir_ack_req", found, 1'b1);
    chk("redir_ack_addr", imem_addr, 16'h1234);

    // reset while in DROP
    lat = 3;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (imem_req && (!outst || cnt > 0)) found = 1;
      else cyc(1'b1, 0, '0);
    end
    chk("drop2_setup", found, 1'b1);
    cyc(1'b1, 1, 16'h0200);
    chk("drop2_req", imem_req, 1'b1);
    do_reset();
    lat = 1;
    for (int i = 0; i < 30 && n_acc == 0; i++) cyc(1'b1, 0, '0);
    chk("restart_pc", last_acc_pc, 16'h0000);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(0, 3);
      cyc(($urandom_range(0, 9) < 7),
          ($urandom_range(0, 19) == 0) ? 1 : 0,
          PW'($urandom));
    end
    chk("rand_progress", (n_acc > 20), 1'b1);
    chk("wrap_seen", seen_wrap, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
